// File: rtl/elevator_car_ctrl_if.sv
// elevator_car_ctrl_if: selector/request inputs and car status outputs of the car controller.
// sel is a level-held target (3'b111 or >= NUM_FLOORS means none); served is its one-cycle acknowledge.
interface elevator_car_ctrl_if;
  logic [9:0] req;
  logic [2:0] sel;
  logic [2:0] current;
  logic       moving;
  logic       dir_up;
  logic       door_open;
  logic [9:0] served;

  modport master (
    output req, sel,
    input  current, moving, dir_up, door_open, served
  );

  modport slave (
    input  req, sel,
    output current, moving, dir_up, door_open, served
  );
endinterface

// File: rtl/elevator_car_ctrl.sv
// elevator_car_ctrl: owns the car floor register, steps one floor per travel period and runs the door.
// Optional macro ELEV_ESTOP_EN adds an estop input that freezes travel and blocks departures.
module elevator_car_ctrl #(
  parameter int NUM_FLOORS    = 7,
  parameter int TRAVEL_CYCLES = 8,
  parameter int DOOR_CYCLES   = 4
) (
  input  logic                clk,
  input  logic                reset_n,
`ifdef ELEV_ESTOP_EN
  input  logic                estop,
`endif
  elevator_car_ctrl_if.slave  bus,
  output logic [2:0]          state_dbg
);

  localparam int TMAX = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [TW-1:0] TRAVEL_LOAD = TW'(TRAVEL_CYCLES - 1);
  localparam logic [TW-1:0] DOOR_LOAD   = TW'(DOOR_CYCLES - 1);
  localparam logic [2:0]    TOP_FLOOR   = 3'(NUM_FLOORS - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    MOVE_UP   = 3'd1,
    MOVE_DOWN = 3'd2,
    SETTLE    = 3'd3,
    DOOR      = 3'd4
  } state_t;

  state_t        state, state_n;
  logic [TW-1:0] timer, timer_n;
  logic [2:0]    cur_q, cur_n;
  logic          dir_q, dir_n;
  logic [9:0]    served_q, served_n;
  logic          halt;
  logic          sel_valid;
  logic          hold;
  logic          at_limit;

`ifdef ELEV_ESTOP_EN
  assign halt = estop;
`else
  assign halt = 1'b0;
`endif

  // 3'b111 is always "no target", even if NUM_FLOORS were ever raised to 8.
  assign sel_valid = (bus.sel != 3'b111) && (bus.sel <= TOP_FLOOR);
  assign hold      = |(bus.req & (10'h200 >> cur_q));
  assign at_limit  = (state == MOVE_UP) ? (cur_q == TOP_FLOOR) : (cur_q == 3'd0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      timer    <= '0;
      cur_q    <= 3'd0;
      dir_q    <= 1'b0;
      served_q <= 10'd0;
    end else begin
      state    <= state_n;
      timer    <= timer_n;
      cur_q    <= cur_n;
      dir_q    <= dir_n;
      served_q <= served_n;
    end
  end

  always_comb begin
    state_n  = state;
    timer_n  = timer;
    cur_n    = cur_q;
    dir_n    = dir_q;
    served_n = 10'd0;
    case (state)
      IDLE: begin
        if (sel_valid) begin
          if (bus.sel == cur_q) begin
            state_n  = DOOR;
            timer_n  = DOOR_LOAD;
            served_n = 10'h200 >> cur_q;
          end else if (!halt) begin
            timer_n = TRAVEL_LOAD;
            if (bus.sel > cur_q) begin
              state_n = MOVE_UP;
              dir_n   = 1'b1;
            end else begin
              state_n = MOVE_DOWN;
              dir_n   = 1'b0;
            end
          end
        end
      end
      MOVE_UP, MOVE_DOWN: begin
        // The step always completes once started; sel is not looked at here.
        if (at_limit) begin
          state_n = SETTLE;
        end else if (!halt) begin
          if (timer == '0) begin
            cur_n   = (state == MOVE_UP) ? cur_q + 3'd1 : cur_q - 3'd1;
            state_n = SETTLE;
          end else begin
            timer_n = timer - 1'b1;
          end
        end
      end
      SETTLE: begin
        state_n = IDLE;
      end
      DOOR: begin
        if (hold) begin
          timer_n = DOOR_LOAD;
        end else if (timer == '0) begin
          state_n = SETTLE;
        end else begin
          timer_n = timer - 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign bus.current   = cur_q;
  assign bus.dir_up    = dir_q;
  assign bus.served    = served_q;
  assign bus.moving    = ((state == MOVE_UP) || (state == MOVE_DOWN)) && !halt;
  assign bus.door_open = (state == DOOR);
  assign state_dbg     = state;

endmodule
